ghost_renderer: RTL and testbench
=================================

# ghost_renderer

Parametrised, pipelined renderer for up to NUM_GHOSTS enemy sprites. It replaces fixed per-colour sprite lookups with a shared 2-bit sprite-code ROM, per-ghost body colours and per-ghost modes (normal, frightened, eyes-only, hidden). It adds a two-frame walk animation, frightened-end blinking and priority with transparency fall-through. It sits between the game logic (ghost positions and modes) and the pixel mixer, and is fed by the display scan counters.

## Interface
Parameters:
- NUM_GHOSTS, 4: number of ghosts, 1..8; index 0 has the highest priority.
- COORD_W, 9: width of all coordinates.
- SPRITE_W / SPRITE_H, 8 / 8: sprite size; each must be a power of two.
- ANIM_FRAMES, 8: video frames per walk-animation toggle, ≥1.
- BLINK_FRAMES, 16: video frames per frightened blink toggle, ≥1.
- GHOST_COLORS, {12'hF00,12'hFBF,12'h0FF,12'hFB5}: packed 12-bit RGB body colour per ghost; ghost i uses bits [12i+11:12i].
- GHOST_MEM_FILE, "rtl/mem/ghost_sprite.mem": ROM image, 2·SPRITE_W·SPRITE_H entries × 2 bits.

Ports:
- clk  in  1  system clock.
- rst  in  1  reset, synchronous, active-low.
- frame_start  in  1  one-cycle pulse at the start of each video frame.
- ghost_x  in  NUM_GHOSTS·COORD_W  packed ghost left edges.
- ghost_y  in  NUM_GHOSTS·COORD_W  packed ghost top edges.
- ghost_mode  in  NUM_GHOSTS·2  packed modes: 00 normal, 01 frightened, 10 eyes-only, 11 hidden.
- fright_end  in  1  frightened period is ending, so blinking is enabled.
- sx, sy  in  COORD_W each  current scan pixel.
- pix_valid  in  1  sx/sy are valid this cycle.
- R, G, B  out  4 each  registered pixel colour.
- hit  out  1  an opaque ghost pixel is being output.
- hit_id  out  3  index of the drawn ghost; 0 when hit=0.
- pix_valid_out  out  1  pix_valid delayed by 2 cycles.

## Operation
- Shadow registers:
  - ghost_x, ghost_y and ghost_mode are sampled into shadow registers only on frame_start.
  - All rendering uses the shadow copies, so a frame never tears.
- Counters (on each frame_start):
  - The animation counter counts 0..ANIM_FRAMES-1; on wrap, anim_sel toggles.
  - The blink counter counts 0..BLINK_FRAMES-1; on wrap, blink_sel toggles.
- Hit test for ghost i:
  - The pixel is inside when sx−x ∈ [0,SPRITE_W) and sy−y ∈ [0,SPRITE_H).
  - Compute in COORD_W+1 bits, with no modular wrap. Sprites near the maximum coordinate clip and never wrap to 0.
  - Mode 11 never hits.
- ROM address = anim_sel·W·H + (sy−y)·SPRITE_W + (sx−x). Use one rams_dist instance per ghost.
- Sprite codes: 0 transparent, 1 body, 2 eye white, 3 pupil.
- Colour by mode:
  - Normal: body = GHOST_COLORS[i], eye white = FFF, pupil = 00F.
  - Frightened: body = 22F, codes 2/3 = FB9.
  - Frightened with fright_end=1 and blink_sel=1: body = FFF, codes 2/3 = F00.
  - Eyes-only: code 1 is transparent; codes 2/3 as in normal mode.
- Priority and output:
  - The lowest-index ghost with an opaque pixel wins; transparent pixels fall through to the next ghost.
  - If no ghost is opaque: RGB = 0, hit = 0.
  - If pix_valid=0, stage-2 outputs are zero.

## Timing
- Two-stage pipeline, latency 2:
  - Stage 1 registers per-ghost in-box flags, ROM addresses and the latched mode.
  - Stage 2 registers RGB, hit, hit_id and pix_valid_out.
- Throughput is one pixel per clock; there are no stalls.
- The pipeline must meet one-pixel-per-cycle throughput at the system clock.
- frame_start in the same cycle as pix_valid: that pixel uses the old shadow values. New values apply from the next cycle.
- Counter updates take effect for pixels entering stage 1 in the cycle after frame_start.
- Reset (rst=0 at a clk edge):
  - All outputs go to 0.
  - Pipeline valids are cleared; anim and blink counters and selects go to 0.
  - Shadow modes go to 11 (hidden), so nothing is drawn until the first frame_start.
  - Reset mid-frame discards in-flight pixels.

## Configuration
- GHOST_RENDERER_BLINK_EN defined: blink counter, blink_sel and the fright_end logic are compiled in, as above.
- Undefined:
  - fright_end is ignored and BLINK_FRAMES is unused.
  - Frightened ghosts are always body 22F, face FB9.
  - No blink counter register exists.

## Test plan
- Reset then frame_start with ghost 0 at (10,20), normal. Scan (10,20)→(17,27): outputs appear 2 cycles after pix_valid and match the ROM frame 0 colours; a pixel at (18,20) gives RGB=0, hit=0.
- Ghosts 0 and 1 overlap at (40,40), ghost 0 transparent at its (0,0) texel: the pixel shows ghost 1 colour, hit_id=1; an opaque overlap shows ghost 0, hit_id=0.
- Change ghost_x mid-frame with no frame_start: rendering keeps the old position. After frame_start it moves.
- Drive ANIM_FRAMES frame_start pulses: the ROM frame switches to frame 1; after 2·ANIM_FRAMES pulses it is back to frame 0.
- Ghost at x=2^COORD_W−4, scan sx=0..3: no hit (clips, no wrap).
- With BLINK_EN, frightened with fright_end=1: the body is 22F for BLINK_FRAMES frames, then FFF. Modes 10 and 11 show eyes-only and invisible respectively; assert rst mid-scan and all outputs are 0 on the next cycle.

Source files
------------

// File: rtl/ghost_renderer.sv
// ghost_renderer: two-stage pipelined renderer for up to NUM_GHOSTS sprites.
// Stage 1 runs the per-ghost box test and forms the ROM addresses from the
// frame-stable shadow copies. Stage 2 reads the sprite ROMs, colours by mode,
// resolves priority and registers the pixel.
// Optional feature macro: GHOST_RENDERER_BLINK_EN (frightened-end blinking).
// Sprite image: rams_dist generates the 2-bit codes itself. Codes are
// 0 transparent, 1 body, 2 eye white, 3 pupil. The two walk frames differ only
// in which columns of the bottom row are transparent.

module rams_dist #(
  parameter int SPRITE_W = 8,
  parameter int SPRITE_H = 8,
  parameter int ADDR_W   = 7
) (
  input  logic [ADDR_W-1:0] addr_i,
  output logic [1:0]        data_o
);
  localparam int XW = $clog2(SPRITE_W);
  localparam int YW = $clog2(SPRITE_H);

  // Address layout is {frame, row, col}; returns the sprite code at that texel.
  function automatic logic [1:0] sprite_code(input logic [ADDR_W-1:0] a);
    logic [1:0] code;
    logic       frame;
    int         row;
    int         col;
    frame = a[ADDR_W-1];
    row   = 32'(a[XW +: YW]);
    col   = 32'(a[XW-1:0]);
    if (row == 32'd0 && (col == 32'd0 || col == SPRITE_W - 32'd1)) begin
      code = 2'd0;
    end else if (row == 32'd2 && (col == 32'd1 || col == SPRITE_W - 32'd3)) begin
      code = 2'd2;
    end else if (row == 32'd2 && (col == 32'd2 || col == SPRITE_W - 32'd2)) begin
      code = 2'd3;
    end else if (row == SPRITE_H - 32'd1 && a[0] == frame) begin
      code = 2'd0;
    end else begin
      code = 2'd1;
    end
    return code;
  endfunction

  assign data_o = sprite_code(addr_i);
endmodule

module ghost_renderer #(
  parameter int                       NUM_GHOSTS   = 4,
  parameter int                       COORD_W      = 9,
  parameter int                       SPRITE_W     = 8,
  parameter int                       SPRITE_H     = 8,
  parameter int                       ANIM_FRAMES  = 8,
  parameter int                       BLINK_FRAMES = 16,
  parameter logic [NUM_GHOSTS*12-1:0] GHOST_COLORS = {12'hF00, 12'hFBF, 12'h0FF, 12'hFB5},
  parameter                           GHOST_MEM_FILE = "rtl/mem/ghost_sprite.mem"
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          frame_start,
  input  logic [NUM_GHOSTS*COORD_W-1:0] ghost_x,
  input  logic [NUM_GHOSTS*COORD_W-1:0] ghost_y,
  input  logic [NUM_GHOSTS*2-1:0]       ghost_mode,
  input  logic                          fright_end,
  input  logic [COORD_W-1:0]            sx,
  input  logic [COORD_W-1:0]            sy,
  input  logic                          pix_valid,
  output logic [3:0]                    R,
  output logic [3:0]                    G,
  output logic [3:0]                    B,
  output logic                          hit,
  output logic [2:0]                    hit_id,
  output logic                          pix_valid_out
);
  localparam int XW     = $clog2(SPRITE_W);
  localparam int YW     = $clog2(SPRITE_H);
  localparam int ADDR_W = 1 + XW + YW;
  localparam int DW     = COORD_W + 1;
  localparam int AW     = (ANIM_FRAMES > 1) ? $clog2(ANIM_FRAMES) : 1;
  localparam logic [AW-1:0] ANIM_LAST = AW'(ANIM_FRAMES - 1);
  // The sprite image comes from rams_dist; the file name is carried for integrators.
  localparam unused_mem_file = GHOST_MEM_FILE;

  // Colour one texel for a given mode; result is {opaque, rgb}.
  function automatic logic [12:0] texel(input logic [1:0] mode, input logic [1:0] code,
                                        input logic [11:0] body, input logic blink);
    logic [12:0] t;
    t = 13'h0000;
    case (mode)
      2'b00: begin
        case (code)
          2'd1:    t = {1'b1, body};
          2'd2:    t = {1'b1, 12'hFFF};
          2'd3:    t = {1'b1, 12'h00F};
          default: t = 13'h0000;
        endcase
      end
      2'b01: begin
        case (code)
          2'd0:    t = 13'h0000;
          2'd1:    t = blink ? {1'b1, 12'hFFF} : {1'b1, 12'h22F};
          default: t = blink ? {1'b1, 12'hF00} : {1'b1, 12'hFB9};
        endcase
      end
      2'b10: begin
        case (code)
          2'd2:    t = {1'b1, 12'hFFF};
          2'd3:    t = {1'b1, 12'h00F};
          default: t = 13'h0000;
        endcase
      end
      default: t = 13'h0000;
    endcase
    return t;
  endfunction

  logic [NUM_GHOSTS*COORD_W-1:0] sh_x_q, sh_y_q;
  logic [NUM_GHOSTS*2-1:0]       sh_mode_q;
  logic [AW-1:0]                 anim_cnt_q, anim_cnt_d;
  logic                          anim_sel_q, anim_sel_d;
  logic                          blink_now_s;

  // Capture ghost state only at frame boundaries so a frame never tears
  always_ff @(posedge clk) begin
    if (!rst) begin
      sh_x_q    <= '0;
      sh_y_q    <= '0;
      sh_mode_q <= '1;
    end else if (frame_start) begin
      sh_x_q    <= ghost_x;
      sh_y_q    <= ghost_y;
      sh_mode_q <= ghost_mode;
    end
  end

  // Walk animation: toggle the ROM frame every ANIM_FRAMES video frames
  always_comb begin
    anim_cnt_d = anim_cnt_q;
    anim_sel_d = anim_sel_q;
    if (frame_start) begin
      if (anim_cnt_q == ANIM_LAST) begin
        anim_cnt_d = '0;
        anim_sel_d = ~anim_sel_q;
      end else begin
        anim_cnt_d = anim_cnt_q + AW'(1'b1);
        anim_sel_d = anim_sel_q;
      end
    end else begin
      anim_cnt_d = anim_cnt_q;
      anim_sel_d = anim_sel_q;
    end
  end

  // Animation counter registers
  always_ff @(posedge clk) begin
    if (!rst) begin
      anim_cnt_q <= '0;
      anim_sel_q <= 1'b0;
    end else begin
      anim_cnt_q <= anim_cnt_d;
      anim_sel_q <= anim_sel_d;
    end
  end

`ifdef GHOST_RENDERER_BLINK_EN
  localparam int BW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
  localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_FRAMES - 1);
  logic [BW-1:0] blink_cnt_q, blink_cnt_d;
  logic          blink_sel_q, blink_sel_d;

  // Blink phase: toggle every BLINK_FRAMES video frames
  always_comb begin
    blink_cnt_d = blink_cnt_q;
    blink_sel_d = blink_sel_q;
    if (frame_start) begin
      if (blink_cnt_q == BLINK_LAST) begin
        blink_cnt_d = '0;
        blink_sel_d = ~blink_sel_q;
      end else begin
        blink_cnt_d = blink_cnt_q + BW'(1'b1);
        blink_sel_d = blink_sel_q;
      end
    end else begin
      blink_cnt_d = blink_cnt_q;
      blink_sel_d = blink_sel_q;
    end
  end

  // Blink counter registers
  always_ff @(posedge clk) begin
    if (!rst) begin
      blink_cnt_q <= '0;
      blink_sel_q <= 1'b0;
    end else begin
      blink_cnt_q <= blink_cnt_d;
      blink_sel_q <= blink_sel_d;
    end
  end

  assign blink_now_s = fright_end & blink_sel_q;
`else
  localparam int unused_blink_frames = BLINK_FRAMES;
  logic unused_fright_end_s;
  assign unused_fright_end_s = fright_end;
  assign blink_now_s         = 1'b0;
`endif

  logic [NUM_GHOSTS-1:0] s1_in_q, s1_in_d;
  logic [ADDR_W-1:0]     s1_addr_q [NUM_GHOSTS];
  logic [ADDR_W-1:0]     s1_addr_d [NUM_GHOSTS];
  logic [1:0]            s1_mode_q [NUM_GHOSTS];
  logic [1:0]            s1_mode_d [NUM_GHOSTS];
  logic                  s1_valid_q, s1_blink_q;

  // Box test in COORD_W+1 bits so sprites at the right/bottom edge clip instead of wrapping
  always_comb begin
    s1_in_d   = '0;
    s1_addr_d = '{default: '0};
    s1_mode_d = '{default: 2'b11};
    for (int i = 0; i < NUM_GHOSTS; i++) begin
      logic [DW-1:0] dx;
      logic [DW-1:0] dy;
      logic [1:0]    mode;
      dx   = {1'b0, sx} - {1'b0, sh_x_q[i*COORD_W +: COORD_W]};
      dy   = {1'b0, sy} - {1'b0, sh_y_q[i*COORD_W +: COORD_W]};
      mode = sh_mode_q[i*2 +: 2];
      s1_in_d[i]   = !dx[DW-1] && !dy[DW-1] && (dx < DW'(SPRITE_W)) &&
                     (dy < DW'(SPRITE_H)) && (mode != 2'b11);
      s1_addr_d[i] = {anim_sel_q, dy[YW-1:0], dx[XW-1:0]};
      s1_mode_d[i] = mode;
    end
  end

  // Stage 1 registers
  always_ff @(posedge clk) begin
    if (!rst) begin
      s1_valid_q <= 1'b0;
      s1_blink_q <= 1'b0;
      s1_in_q    <= '0;
      s1_addr_q  <= '{default: '0};
      s1_mode_q  <= '{default: 2'b11};
    end else begin
      s1_valid_q <= pix_valid;
      s1_blink_q <= blink_now_s;
      s1_in_q    <= s1_in_d;
      s1_addr_q  <= s1_addr_d;
      s1_mode_q  <= s1_mode_d;
    end
  end

  logic [1:0] code_s [NUM_GHOSTS];

  for (genvar g = 0; g < NUM_GHOSTS; g++) begin : g_rom
    rams_dist #(.SPRITE_W(SPRITE_W), .SPRITE_H(SPRITE_H), .ADDR_W(ADDR_W)) u_rom (
      .addr_i (s1_addr_q[g]),
      .data_o (code_s[g])
    );
  end

  logic [11:0] rgb_d, rgb_q;
  logic        hit_d, hit_q;
  logic [2:0]  id_d, id_q;
  logic        vout_q;

  // Priority: walk from the lowest-priority ghost up so lower indices overwrite
  always_comb begin
    rgb_d = 12'h000;
    hit_d = 1'b0;
    id_d  = 3'd0;
    for (int i = NUM_GHOSTS - 1; i >= 0; i--) begin
      logic [12:0] t;
      t = texel(s1_mode_q[i], code_s[i], GHOST_COLORS[i*12 +: 12], s1_blink_q);
      if (s1_valid_q && s1_in_q[i] && t[12]) begin
        rgb_d = t[11:0];
        hit_d = 1'b1;
        id_d  = 3'(i);
      end else begin
        rgb_d = rgb_d;
        hit_d = hit_d;
        id_d  = id_d;
      end
    end
  end

  // Stage 2 output registers
  always_ff @(posedge clk) begin
    if (!rst) begin
      rgb_q  <= 12'h000;
      hit_q  <= 1'b0;
      id_q   <= 3'd0;
      vout_q <= 1'b0;
    end else begin
      rgb_q  <= rgb_d;
      hit_q  <= hit_d;
      id_q   <= id_d;
      vout_q <= s1_valid_q;
    end
  end

  assign R             = rgb_q[11:8];
  assign G             = rgb_q[7:4];
  assign B             = rgb_q[3:0];
  assign hit           = hit_q;
  assign hit_id        = id_q;
  assign pix_valid_out = vout_q;
endmodule

// File: tb/tb_ghost_renderer.sv
// Scoreboard bench for ghost_renderer: stimulus pushes hand-computed expected
// pixels, a negedge monitor pops and compares whenever pix_valid_out is high
// and checks that outputs are zero otherwise.
module tb_ghost_renderer;
  localparam int NG = 4;
  localparam int CW = 9;
`ifdef GHOST_RENDERER_BLINK_EN
  localparam bit BLINK = 1'b1;
`else
  localparam bit BLINK = 1'b0;
`endif

  logic             clk = 1'b0;
  logic             rst, frame_start, fright_end, pix_valid;
  logic [NG*CW-1:0] ghost_x, ghost_y;
  logic [NG*2-1:0]  ghost_mode;
  logic [CW-1:0]    sx, sy;
  logic [3:0]       R, G, B;
  logic             hit, pix_valid_out;
  logic [2:0]       hit_id;

  always #5 clk = ~clk;

  ghost_renderer dut (
    .clk(clk), .rst(rst), .frame_start(frame_start),
    .ghost_x(ghost_x), .ghost_y(ghost_y), .ghost_mode(ghost_mode),
    .fright_end(fright_end), .sx(sx), .sy(sy), .pix_valid(pix_valid),
    .R(R), .G(G), .B(B), .hit(hit), .hit_id(hit_id), .pix_valid_out(pix_valid_out)
  );

  typedef struct { logic [15:0] exp; int x; int y; } exp_t;
  exp_t sb_q[$];
  exp_t mon_e;
  int   n_checks = 0;
  int   n_pass   = 0;
  logic mon_en   = 1'b0;

  task automatic check(input string name, input logic [15:0] got, input logic [15:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got rgb=%h hit=%b id=%0d, expected rgb=%h hit=%b id=%0d",
                  name, got[15:4], got[3], got[2:0], exp[15:4], exp[3], exp[2:0]);
  endtask

  // Monitor: compare every presented pixel against the scoreboard head
  always @(negedge clk) begin
    if (mon_en) begin
      if (pix_valid_out === 1'b1) begin
        if (sb_q.size() == 0) begin
          n_checks++;
          $display("FAIL unexpected_output: got rgb=%h%h%h with empty scoreboard", R, G, B);
        end else begin
          mon_e = sb_q.pop_front();
          check($sformatf("pix(%0d,%0d)", mon_e.x, mon_e.y), {R, G, B, hit, hit_id}, mon_e.exp);
        end
      end else begin
        check("idle_zero", {R, G, B, hit, hit_id}, 16'h0000);
      end
    end
  end

  task automatic drive(input int x, input int y, input logic [11:0] rgb, input logic h,
                       input logic [2:0] id, input logic fs = 1'b0, input logic push = 1'b1);
    exp_t e;
    @(posedge clk); #1;
    sx = CW'(x); sy = CW'(y); pix_valid = 1'b1; frame_start = fs;
    if (push) begin
      e.exp = {rgb, h, id}; e.x = x; e.y = y;
      sb_q.push_back(e);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk); #1;
      pix_valid = 1'b0; frame_start = 1'b0;
    end
  endtask

  task automatic pulse();
    @(posedge clk); #1;
    pix_valid = 1'b0; frame_start = 1'b1;
    @(posedge clk); #1;
    frame_start = 1'b0;
  endtask

  task automatic set_ghost(input int i, input int x, input int y, input logic [1:0] m);
    ghost_x[i*CW +: CW] = CW'(x);
    ghost_y[i*CW +: CW] = CW'(y);
    ghost_mode[i*2 +: 2] = m;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    rst = 1'b0; frame_start = 1'b0; pix_valid = 1'b0; fright_end = 1'b1;
    sx = '0; sy = '0; ghost_x = '0; ghost_y = '0; ghost_mode = '1;
    repeat (3) @(posedge clk); #1;
    check("reset_out", {R, G, B, hit, hit_id}, 16'h0000);
    check("reset_valid", {15'd0, pix_valid_out}, 16'h0000);
    rst = 1'b1; mon_en = 1'b1;

    // Nothing drawn before the first frame_start
    drive(1, 1, 12'h000, 1'b0, 3'd0);
    drive(0, 0, 12'h000, 1'b0, 3'd0);

    // Ghost 0 alone at (10,20), normal, frame 0 (pulse 1)
    set_ghost(0, 10, 20, 2'b00);
    pulse();
    drive(10, 20, 12'h000, 1'b0, 3'd0);
    drive(11, 20, 12'hFB5, 1'b1, 3'd0);
    drive(17, 20, 12'h000, 1'b0, 3'd0);
    drive(11, 22, 12'hFFF, 1'b1, 3'd0);
    drive(12, 22, 12'h00F, 1'b1, 3'd0);
    drive(15, 22, 12'hFFF, 1'b1, 3'd0);
    drive(16, 22, 12'h00F, 1'b1, 3'd0);
    drive(13, 24, 12'hFB5, 1'b1, 3'd0);
    drive(10, 27, 12'h000, 1'b0, 3'd0);
    drive(11, 27, 12'hFB5, 1'b1, 3'd0);
    drive(17, 27, 12'hFB5, 1'b1, 3'd0);
    drive(18, 20, 12'h000, 1'b0, 3'd0);
    drive(9, 20, 12'h000, 1'b0, 3'd0);
    idle(3);

    // Overlap, eyes-only and frightened ghosts (pulse 2)
    set_ghost(0, 40, 40, 2'b00);
    set_ghost(1, 39, 40, 2'b00);
    set_ghost(2, 100, 100, 2'b10);
    set_ghost(3, 200, 100, 2'b01);
    pulse();
    drive(40, 40, 12'h0FF, 1'b1, 3'd1);
    drive(41, 40, 12'hFB5, 1'b1, 3'd0);
    drive(39, 40, 12'h000, 1'b0, 3'd0);
    drive(41, 42, 12'hFFF, 1'b1, 3'd0);
    drive(101, 100, 12'h000, 1'b0, 3'd0);
    drive(101, 102, 12'hFFF, 1'b1, 3'd2);
    drive(102, 102, 12'h00F, 1'b1, 3'd2);
    drive(201, 100, 12'h22F, 1'b1, 3'd3);
    drive(201, 102, 12'hFB9, 1'b1, 3'd3);
    drive(200, 100, 12'h000, 1'b0, 3'd0);
    idle(2);

    // Mid-frame move is ignored until frame_start; same-cycle pixel uses old (pulse 3)
    set_ghost(0, 60, 40, 2'b00);
    drive(41, 40, 12'hFB5, 1'b1, 3'd0);
    drive(61, 40, 12'h000, 1'b0, 3'd0);
    drive(41, 40, 12'hFB5, 1'b1, 3'd0, 1'b1);
    drive(41, 40, 12'h0FF, 1'b1, 3'd1);
    drive(61, 40, 12'hFB5, 1'b1, 3'd0);
    idle(2);

    // Walk animation: frame 0 now, frame 1 after pulse 8, frame 0 after pulse 16
    drive(60, 47, 12'h000, 1'b0, 3'd0);
    drive(61, 47, 12'hFB5, 1'b1, 3'd0);
    repeat (5) pulse();
    drive(60, 47, 12'hFB5, 1'b1, 3'd0);
    drive(61, 47, 12'h000, 1'b0, 3'd0);
    drive(201, 100, 12'h22F, 1'b1, 3'd3);
    repeat (7) pulse();
    drive(60, 47, 12'hFB5, 1'b1, 3'd0);
    drive(201, 100, 12'h22F, 1'b1, 3'd3);
    pulse();
    drive(60, 47, 12'h000, 1'b0, 3'd0);
    drive(61, 47, 12'hFB5, 1'b1, 3'd0);
    drive(201, 100, BLINK ? 12'hFFF : 12'h22F, 1'b1, 3'd3);
    drive(201, 102, BLINK ? 12'hF00 : 12'hFB9, 1'b1, 3'd3);
    drive(101, 102, 12'hFFF, 1'b1, 3'd2);
    idle(3);
    fright_end = 1'b0;
    drive(201, 100, 12'h22F, 1'b1, 3'd3);
    drive(201, 102, 12'hFB9, 1'b1, 3'd3);
    idle(2);
    fright_end = 1'b1;

    // Right-edge clipping: ghost 2 at x=508 never wraps to column 0 (pulse 17)
    set_ghost(2, 508, 0, 2'b00);
    pulse();
    drive(0, 0, 12'h000, 1'b0, 3'd0);
    drive(1, 0, 12'h000, 1'b0, 3'd0);
    drive(2, 0, 12'h000, 1'b0, 3'd0);
    drive(3, 0, 12'h000, 1'b0, 3'd0);
    drive(508, 0, 12'h000, 1'b0, 3'd0);
    drive(509, 0, 12'hFBF, 1'b1, 3'd2);
    drive(511, 0, 12'hFBF, 1'b1, 3'd2);
    idle(2);

    // Reset mid-scan: the in-flight pixel is discarded and shadows go hidden
    drive(509, 0, 12'hFBF, 1'b1, 3'd2);
    drive(510, 0, 12'h000, 1'b0, 3'd0, 1'b0, 1'b0);
    @(posedge clk); #1;
    rst = 1'b0; sx = CW'(511); pix_valid = 1'b1;
    @(posedge clk); #1;
    check("mid_reset_out", {R, G, B, hit, hit_id}, 16'h0000);
    check("mid_reset_valid", {15'd0, pix_valid_out}, 16'h0000);
    rst = 1'b1; pix_valid = 1'b0;
    drive(61, 40, 12'h000, 1'b0, 3'd0);
    drive(1, 1, 12'h000, 1'b0, 3'd0);
    idle(5);

    check("scoreboard_drained", 16'(sb_q.size()), 16'h0000);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
